display_select: RTL

DISPLAY_SELECT -- requirements
Module: display_select

---
 rtl/display_select.sv | 82 ++++++++
 1 files changed

// File: rtl/display_select.sv
// display_select: picks one of N_SRC packed time sources for display, auto-reverts to home after HOLD_SEC seconds, blinks while editing
module display_select #(
  parameter int N_SRC = 4,
  parameter int HOLD_SEC = 10,
  localparam int IW = $clog2(N_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               one_second,
  input  logic               sel_req,
  input  logic [IW-1:0]      sel_idx,
  input  logic               set_mode,
  input  logic [4*N_SRC-1:0] HOURS_IN,
  input  logic [6*N_SRC-1:0] MINUTES_IN,
  input  logic [N_SRC-1:0]   AM_PM_IN,
  output logic [3:0]         HOURS_OUT,
  output logic [5:0]         MINUTES_OUT,
  output logic               AM_PM_OUT,
  output logic [IW-1:0]      SRC_OUT,
  output logic               BLANK_OUT
);
  typedef enum logic [1:0] {HOME, ALT, EDIT} state_t;
  localparam logic [7:0] HOLD = 8'(HOLD_SEC);
  state_t state, state_nxt;
  logic [IW-1:0] src, src_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic phase, phase_nxt;
  logic sel_ok;
  logic [3:0] hours_nxt;
  logic [5:0] minutes_nxt;
  logic am_pm_nxt;
  assign sel_ok = sel_req && (32'(sel_idx) < N_SRC);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HOME;
      src <= '0;
      cnt <= '0;
      phase <= 1'b0;
      HOURS_OUT <= '0;
      MINUTES_OUT <= '0;
      AM_PM_OUT <= 1'b0;
      SRC_OUT <= '0;
      BLANK_OUT <= 1'b0;
    end else begin
      state <= state_nxt;
      src <= src_nxt;
      cnt <= cnt_nxt;
      phase <= phase_nxt;
      HOURS_OUT <= hours_nxt;
      MINUTES_OUT <= minutes_nxt;
      AM_PM_OUT <= am_pm_nxt;
      SRC_OUT <= src_nxt;
      BLANK_OUT <= phase_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    src_nxt = src;
    cnt_nxt = cnt;
    phase_nxt = 1'b0;
    if (set_mode) begin
      state_nxt = EDIT;
      phase_nxt = (state == EDIT) ? phase ^ one_second : 1'b0;
    end else if (state == EDIT) begin
      state_nxt = (src == '0) ? HOME : ALT;
      cnt_nxt = (src == '0) ? 8'd0 : HOLD;
    end else if (sel_ok) begin
      state_nxt = (sel_idx == '0) ? HOME : ALT;
      src_nxt = sel_idx;
      cnt_nxt = (sel_idx == '0) ? 8'd0 : HOLD;
    end else if (state == ALT && one_second) begin
      state_nxt = (cnt <= 8'd1) ? HOME : ALT;
      src_nxt = (cnt <= 8'd1) ? '0 : src;
      cnt_nxt = (cnt <= 8'd1) ? 8'd0 : cnt - 8'd1;
    end
  end
  always_comb begin
    hours_nxt = HOURS_IN[4*int'(src_nxt) +: 4];
    minutes_nxt = MINUTES_IN[6*int'(src_nxt) +: 6];
    am_pm_nxt = AM_PM_IN[src_nxt];
  end
endmodule
